// File: rtl/net_conf_sequencer_if.sv
// Purpose: requester, broadcast and configuration-bus signal bundle for
//          net_conf_sequencer.
// Signals:
//   req0_*/req1_*  valid/ready/64-bit data handshake per requester
//   bcast_*        broadcast start, thread id, PC_MAX and PC_LOOP operands
//   bcast_busy     broadcast in progress
//   conf_done      one-cycle pulse when a broadcast completes
//   conf_bus_out   registered 64-bit configuration bus to the switch readers
// Modports: master = host/loader side, slave = sequencer side.
interface net_conf_sequencer_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_data;
    logic        bcast_start;
    logic [3:0]  bcast_thread_id;
    logic [31:0] bcast_pc_max;
    logic [31:0] bcast_pc_loop;
    logic        bcast_busy;
    logic        conf_done;
    logic [63:0] conf_bus_out;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        output bcast_start, bcast_thread_id, bcast_pc_max, bcast_pc_loop,
        input  req0_ready, req1_ready, bcast_busy, conf_done, conf_bus_out
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  bcast_start, bcast_thread_id, bcast_pc_max, bcast_pc_loop,
        output req0_ready, req1_ready, bcast_busy, conf_done, conf_bus_out
    );
endinterface

// File: rtl/net_conf_sequencer.sv
// Purpose: arbitrates two configuration-word requesters onto the CGRA network
//          configuration bus (round-robin, one word per cycle) and, when the
//          broadcast engine is built in, emits a PC_MAX/PC_LOOP word pair for
//          every switch of a thread.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   bus (slave)   requester handshakes, broadcast controls, bcast_busy,
//                 conf_done and conf_bus_out (see net_conf_sequencer_if)
// Parameter: NUM_SWITCHES - switches addressed by a broadcast (1..65535).
// Build option: define NET_CONF_SEQ_BCAST_EN to include the broadcast engine;
//               without it the block is a plain two-way round-robin arbiter.
module net_conf_sequencer #(
    parameter int unsigned NUM_SWITCHES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    net_conf_sequencer_if.slave  bus
);
    localparam int unsigned W_DATA = 64;

    logic [W_DATA-1:0] bus_d, bus_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              rr_ptr_d, rr_ptr_q;
    logic              arb_en_c, grant0_c, grant1_c;

`ifdef NET_CONF_SEQ_BCAST_EN
    localparam int unsigned    W_SW         = 16;
    localparam logic [7:0]     TYPE_PC_MAX  = 8'd8;
    localparam logic [7:0]     TYPE_PC_LOOP = 8'd9;
    localparam logic [W_SW-1:0] LAST_SW     = W_SW'(NUM_SWITCHES - 1);

    typedef enum logic [1:0] {IDLE, BC_MAX, BC_LOOP} state_e;

    state_e          state_d, state_q;
    logic [W_SW-1:0] sw_cnt_d, sw_cnt_q;
    logic [3:0]      thread_d, thread_q;
    logic [31:0]     pc_max_d, pc_max_q;
    logic [31:0]     pc_loop_d, pc_loop_q;
`else
    logic unused_bcast;
    assign unused_bcast = ^{bus.bcast_start, bus.bcast_thread_id, bus.bcast_pc_max,
                            bus.bcast_pc_loop, 32'(NUM_SWITCHES)};
`endif

    // Grant selection: requesters only win in IDLE with no broadcast starting
    always_comb begin
        arb_en_c = ~rst;
`ifdef NET_CONF_SEQ_BCAST_EN
        arb_en_c = ~rst & (state_q == IDLE) & ~bus.bcast_start;
`endif
        grant0_c = arb_en_c & bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
        grant1_c = arb_en_c & bus.req1_valid & (~bus.req0_valid | rr_ptr_q);
    end

    assign bus.req0_ready = grant0_c;
    assign bus.req1_ready = grant1_c;

    // Next-state and registered-output computation
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        bus_d    = '0;
        if (arb_en_c & bus.req0_valid & bus.req1_valid) begin
            rr_ptr_d = ~rr_ptr_q;
        end
        if (grant0_c) begin
            bus_d = bus.req0_data;
        end else if (grant1_c) begin
            bus_d = bus.req1_data;
        end
`ifdef NET_CONF_SEQ_BCAST_EN
        state_d   = state_q;
        sw_cnt_d  = sw_cnt_q;
        thread_d  = thread_q;
        pc_max_d  = pc_max_q;
        pc_loop_d = pc_loop_q;
        case (state_q)
            IDLE: begin
                if (bus.bcast_start) begin
                    state_d   = BC_MAX;
                    sw_cnt_d  = '0;
                    thread_d  = bus.bcast_thread_id;
                    pc_max_d  = bus.bcast_pc_max;
                    pc_loop_d = bus.bcast_pc_loop;
                end
            end
            BC_MAX: begin
                state_d = BC_LOOP;
            end
            BC_LOOP: begin
                if (sw_cnt_q == LAST_SW) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sw_cnt_d = sw_cnt_q + W_SW'(1);
                    state_d  = BC_MAX;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Broadcast word is registered together with the state it belongs to,
        // so the word is on the bus during that state's cycle.
        if (state_d == BC_MAX) begin
            bus_d = {pc_max_d, 4'b0, thread_d, sw_cnt_d, TYPE_PC_MAX};
        end else if (state_d == BC_LOOP) begin
            bus_d = {pc_loop_d, 4'b0, thread_d, sw_cnt_d, TYPE_PC_LOOP};
        end
        busy_d = (state_d != IDLE);
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rr_ptr_q  <= 1'b0;
`ifdef NET_CONF_SEQ_BCAST_EN
            state_q   <= IDLE;
            sw_cnt_q  <= '0;
            thread_q  <= '0;
            pc_max_q  <= '0;
            pc_loop_q <= '0;
`endif
        end else begin
            bus_q     <= bus_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef NET_CONF_SEQ_BCAST_EN
            state_q   <= state_d;
            sw_cnt_q  <= sw_cnt_d;
            thread_q  <= thread_d;
            pc_max_q  <= pc_max_d;
            pc_loop_q <= pc_loop_d;
`endif
        end
    end

    assign bus.conf_bus_out = bus_q;
    assign bus.bcast_busy   = busy_q;
    assign bus.conf_done    = done_q;
endmodule

// File: doc/net_conf_sequencer.md
# net_conf_sequencer

Sequences and arbitrates the 64-bit CGRA network configuration bus that feeds every per-switch configuration reader. Two requesters share the bus, each supplying pre-formatted configuration words over a valid/ready handshake, and a round-robin arbiter grants one word per cycle. An optional broadcast engine generates the PC_MAX/PC_LOOP word pair for every switch of a thread automatically. The block sits between the host configuration loader and the broadcast `conf_bus_in` of all switch readers.

## Interface
- `NUM_SWITCHES`, default 4: number of switches addressed by broadcast, 1..65535.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_ready`  out  1  requester 0 word accepted this cycle (combinational).
- `req0_data`  in  64  requester 0 configuration word.
- `req1_valid`, `req1_ready`, `req1_data`: same as requester 0, for requester 1.
- `bcast_start`  in  1  start a broadcast (single-cycle pulse or level).
- `bcast_thread_id`  in  4  thread id for broadcast words.
- `bcast_pc_max`  in  32  PC_MAX value.
- `bcast_pc_loop`  in  32  PC_LOOP value.
- `bcast_busy`  out  1  broadcast in progress.
- `conf_done`  out  1  one-cycle pulse when a broadcast completes.
- `conf_bus_out`  out  64  registered configuration bus to the switch readers.

## Operation
- Word layout on the bus:
  - [7:0] type: 8 = PC_MAX, 9 = PC_LOOP, 10 = NET_SWITCH.
  - [23:8] switch number.
  - [27:24] thread id.
  - [39:28] instruction address.
  - [63:40] switch config. For PC_MAX/PC_LOOP words, [63:32] carries the value.
- The idle word is all-zero. Type 0 matches no command, so the idle word is ignored by the readers.
- FSM states: IDLE, BC_MAX, BC_LOOP. Internal registers: `sw_cnt` (16 bit), `rr_ptr` (1 bit), captured thread id, pc_max and pc_loop.
- IDLE:
  - If `bcast_start`=1, go to BC_MAX and capture the operands. `sw_cnt`=0. No request is granted this cycle. Broadcast has priority over requesters.
  - Otherwise, arbitrate. With one valid requester, grant it. With both valid, grant the requester `rr_ptr` points to, then flip `rr_ptr` to the other requester. `rr_ptr` changes only on a contended grant.
  - At most one `reqN_ready` is high per cycle, and only in IDLE. Ready does not depend on any other condition.
  - Granted data is registered into `conf_bus_out` next cycle. With no grant, `conf_bus_out` is 0.
- BC_MAX: emit PC_MAX word {pc_max, 4'b0, thread, sw_cnt, 8'd8}, then go to BC_LOOP.
- BC_LOOP: emit PC_LOOP word {pc_loop, 4'b0, thread, sw_cnt, 8'd9}.
  - If `sw_cnt`==NUM_SWITCHES-1, go to IDLE and pulse `conf_done` next cycle.
  - Otherwise, increment `sw_cnt` and go to BC_MAX.
- `bcast_busy` = state ≠ IDLE. `bcast_start` is ignored while busy. Requesters get ready=0 throughout the broadcast.
- Reset values: state IDLE, `conf_bus_out`=0, `bcast_busy`=0, `conf_done`=0, `rr_ptr`=0 (requester 0 favoured first), `sw_cnt`=0.
- Reset mid-broadcast aborts the broadcast. The next cycle shows bus 0 and no `conf_done`.

## Timing
- Request latency: handshake at cycle t → word on `conf_bus_out` during t+1 only.
- Back-to-back grants are allowed: one word per cycle sustained.
- Broadcast sampled at t:
  - Words appear on t+1 .. t+2·NUM_SWITCHES, alternating PC_MAX/PC_LOOP per switch in ascending switch order.
  - `bcast_busy` is high for exactly those cycles.
  - `conf_done`=1 and bus=0 at t+2·NUM_SWITCHES+1.
- First request grant after a broadcast: at the earliest, the cycle `conf_done` is high.
- Outputs `conf_bus_out`, `bcast_busy` and `conf_done` are registered. `reqN_ready` is combinational from state, `rr_ptr` and valids.

## Configuration
- `NET_CONF_SEQ_BCAST_EN` defined: broadcast engine present, as described above.
- `NET_CONF_SEQ_BCAST_EN` undefined:
  - BC states, counter and operand registers are removed.
  - `bcast_start` and the operand ports are ignored.
  - `bcast_busy` and `conf_done` are held at 0.
  - The block is a pure two-way round-robin arbiter. Ports are identical in both builds.

## Test plan
- Reset: hold rst 3 cycles with both valids high → both readies 0 during reset, bus 0, busy 0, done 0.
- Single requester: req0 presents 0x0000_0ABC_0000_010A for one cycle → req0_ready=1 that cycle; bus equals that word next cycle, then 0.
- Contention: both valid for 4 cycles → grants alternate 0,1,0,1. Bus shows req0, req1, req0, req1 data on consecutive cycles.
- Broadcast, NUM_SWITCHES=4, thread=3, pc_max=5, pc_loop=2:
  - 8 words follow; the first is 0x0000_0005_0300_0008, the last 0x0000_0002_0300_0309.
  - busy is high 8 cycles, done pulses once, and requester valids are stalled throughout.
- Broadcast start while req0 valid in the same cycle → broadcast wins. req0 is granted in the cycle done is high.
- rst asserted at the 3rd broadcast word → bus 0 next cycle, no done pulse. A fresh broadcast restarts at switch 0.
